stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
- Consumes the periodic one-cycle tick produced by the stopwatch's pulse generator (nominally one tick per 10 ms).
- Accumulates elapsed time as cascaded BCD digits MM:SS.CC (minutes, seconds, centiseconds).
- Owns the start/stop, clear and lap control of the stopwatch.
- Drives the pulse generator's enable and clear, and feeds the display/7-segment stage downstream.

Parameters:
- WRAP, 1: 1 = roll over 59:59.99 -> 00:00.00 and keep running; 0 = saturate at 59:59.99 and pause.
- MIN_MAX, 59: maximum minutes value, binary 0..99; the minute digits roll/saturate at this value.

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, synchronous, active-low.
- tick  input  1  one-cycle count pulse from the pulse generator.
- start_stop  input  1  one-cycle pulse (debounced upstream); toggles run/pause.
- clear  input  1  one-cycle pulse; zero the time and return to IDLE.
- lap  input  1  one-cycle pulse; toggles display freeze while counting continues.
- gen_ena  output  1  enable to the pulse generator.
- gen_clear  output  1  clear to the pulse generator.
- cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens  output  4 each  displayed BCD digits.
- running  output  1  high in state RUN.
- lap_active  output  1  high while the display is frozen.
- overflow  output  1  one-cycle pulse on 59:59.99 (MIN_MAX:59.99) + tick.

Behaviour:
- One clock. Reset is synchronous, active-low, sampled only on the rising edge of clk.
- Reset values (nrst=0 at an edge):
  - state = IDLE; all live and frozen digits = 0.
  - running = 0, lap_active = 0, overflow = 0, gen_ena = 0.
  - gen_clear = 1 while nrst is low, so the generator restarts in phase.
- FSM states IDLE, RUN, PAUSED:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUN.
  - any state + clear -> IDLE.
- Per-edge priority: nrst > clear > start_stop > lap > tick.
- gen_ena = (state==RUN), registered, so it follows the state. gen_clear = 1 for exactly the one cycle after clear is sampled, otherwise 0.
- Counting:
  - tick is counted only if the state at the sampling edge is RUN.
  - Live digits update on that same edge, so they are visible one cycle after the tick cycle.
  - cs_ones 0..9, carry into cs_tens 0..9, into s_ones 0..9, into s_tens 0..5, into minutes 0..MIN_MAX.
  - Carries ripple within the same cycle; there is no multi-cycle propagation.
  - Example: 00:59.99 + tick -> 01:00.00 in one edge.
- Simultaneous events:
  - start_stop and tick in RUN: the tick IS counted and the state goes to PAUSED.
  - start_stop and tick in PAUSED or IDLE: the tick is ignored.
  - clear with anything else: clear wins, and the tick is not counted.
- Terminal count: MIN_MAX:59.99 + tick.
  - overflow = 1 for one cycle.
  - WRAP=1: digits -> 00:00.00, state stays RUN.
  - WRAP=0: digits hold MIN_MAX:59.99 and state -> PAUSED (gen_ena drops the next cycle); later start_stop -> RUN, but ticks cause no change beyond terminal except repeated overflow pulses.
- Lap:
  - Lap in RUN with lap_active=0: copy the live digits (value after this edge's tick, if any) into the frozen registers and set lap_active=1.
  - Lap with lap_active=1, in any state: lap_active=0.
  - Lap in IDLE or PAUSED with lap_active=0 is ignored.
  - Clear forces lap_active=0.
- Output mux: displayed digits = frozen registers when lap_active=1, else live digits.
- Invariant: each digit never holds a non-BCD value (>9; tens-of-seconds >5).

Test Plan:
- Reset and clear:
  - nrst=0 for 3 cycles -> all digits 0, running=0, gen_ena=0, gen_clear=1 during reset.
  - Then clear pulse mid-count at 00:03.47 -> next cycle digits 00:00.00, state IDLE, gen_clear=1 for exactly 1 cycle.
- Count and carry: start_stop, then 6000 ticks spaced 10 clks -> 01:00.00, with intermediate 00:59.99 observed, running=1, gen_ena=1.
- Pause with simultaneous tick:
  - At 00:00.41 assert start_stop and tick in the same cycle -> 00:00.42, running=0.
  - 5 more ticks -> still 00:00.42.
  - start_stop -> resumes.
- Lap:
  - At 00:01.20, lap -> outputs frozen at 00:01.20, lap_active=1.
  - 30 ticks -> outputs still 00:01.20.
  - lap -> outputs 00:01.50, lap_active=0.
- Wrap, WRAP=1, MIN_MAX=1: preload by ticking to 01:59.99, tick -> 00:00.00, overflow=1 for one cycle, running=1.
- Saturate, WRAP=0, MIN_MAX=1: at 01:59.99, tick -> digits hold 01:59.99, overflow pulse, running=0, gen_ena=0 the following cycle.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: counts generator ticks into BCD MM:SS.CC and owns the
// run/pause, clear and lap-freeze control plus the pulse generator's enable/clear.
module stopwatch_time_counter #(
   parameter bit WRAP    = 1'b1,
   parameter int MIN_MAX = 59
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic       gen_ena,
   output logic       gen_clear,
   output logic [3:0] cs_ones,
   output logic [3:0] cs_tens,
   output logic [3:0] s_ones,
   output logic [3:0] s_tens,
   output logic [3:0] m_ones,
   output logic [3:0] m_tens,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

   typedef struct packed {
      logic [3:0] m_tens;
      logic [3:0] m_ones;
      logic [3:0] s_tens;
      logic [3:0] s_ones;
      logic [3:0] cs_tens;
      logic [3:0] cs_ones;
   } bcd_time_t;

   localparam logic [3:0] MM_TENS = 4'(MIN_MAX / 10);
   localparam logic [3:0] MM_ONES = 4'(MIN_MAX % 10);
   localparam bcd_time_t  T_MAX   = {MM_TENS, MM_ONES, 4'd5, 4'd9, 4'd9, 4'd9};

   state_t    state_q, state_d;
   bcd_time_t live_q, live_d;
   bcd_time_t frozen_q, frozen_d;
   logic      lap_active_q, lap_active_d;
   logic      overflow_q, overflow_d;
   logic      gen_ena_q, gen_ena_d;
   logic      gen_clear_q, gen_clear_d;
   logic      cnt, terminal;
   bcd_time_t disp;

   // Full carry ripple in one step; the terminal value is handled by the caller.
   function automatic bcd_time_t bcd_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.cs_ones != 4'd9) r.cs_ones = t.cs_ones + 4'd1;
      else begin
         r.cs_ones = '0;
         if (t.cs_tens != 4'd9) r.cs_tens = t.cs_tens + 4'd1;
         else begin
            r.cs_tens = '0;
            if (t.s_ones != 4'd9) r.s_ones = t.s_ones + 4'd1;
            else begin
               r.s_ones = '0;
               if (t.s_tens != 4'd5) r.s_tens = t.s_tens + 4'd1;
               else begin
                  r.s_tens = '0;
                  if (t.m_ones != 4'd9) r.m_ones = t.m_ones + 4'd1;
                  else begin
                     r.m_ones = '0;
                     r.m_tens = t.m_tens + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   assign cnt      = (state_q == RUN) && tick && !clear;
   assign terminal = (live_q == T_MAX);

   always_ff @(posedge clk) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) state_d = IDLE;
      else if (start_stop) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSED;
            PAUSED:  state_d = RUN;
            default: state_d = IDLE;
         endcase
      end else if (cnt && terminal && !WRAP) state_d = PAUSED;
   end

   always_comb begin
      running   = (state_q == RUN);
      gen_ena_d = running;
   end

   always_comb begin
      live_d       = live_q;
      frozen_d     = frozen_q;
      lap_active_d = lap_active_q;
      overflow_d   = cnt && terminal;
      gen_clear_d  = clear;
      if (clear) begin
         live_d       = '0;
         frozen_d     = '0;
         lap_active_d = 1'b0;
      end else begin
         if (cnt) begin
            if (!terminal)  live_d = bcd_inc(live_q);
            else if (WRAP)  live_d = '0;
         end
         // Freeze captures the post-tick value so the lap time includes this edge.
         if (lap) begin
            if (lap_active_q) lap_active_d = 1'b0;
            else if (state_q == RUN) begin
               lap_active_d = 1'b1;
               frozen_d     = live_d;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         live_q       <= '0;
         frozen_q     <= '0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
         gen_ena_q    <= 1'b0;
         gen_clear_q  <= 1'b0;
      end else begin
         live_q       <= live_d;
         frozen_q     <= frozen_d;
         lap_active_q <= lap_active_d;
         overflow_q   <= overflow_d;
         gen_ena_q    <= gen_ena_d;
         gen_clear_q  <= gen_clear_d;
      end
   end

   // Held in clear for the whole reset so the generator restarts in phase.
   assign gen_clear  = gen_clear_q | ~nrst;
   assign gen_ena    = gen_ena_q;
   assign lap_active = lap_active_q;
   assign overflow   = overflow_q;
   assign disp       = lap_active_q ? frozen_q : live_q;
   assign cs_ones    = disp.cs_ones;
   assign cs_tens    = disp.cs_tens;
   assign s_ones     = disp.s_ones;
   assign s_tens     = disp.s_tens;
   assign m_ones     = disp.m_ones;
   assign m_tens     = disp.m_tens;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench: default instance for control/carry/lap, plus MIN_MAX=1
// instances (wrap and saturate) sharing one stimulus set.
module tb_stopwatch_time_counter;

   logic clk = 1'b0;
   logic nrst;
   logic tick, start_stop, clear, lap;
   logic tick2, ss2, clear2, lap2;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // default instance
   logic       gen_ena, gen_clear, running, lap_active, overflow;
   logic [3:0] cs_o, cs_t, s_o, s_t, m_o, m_t;
   logic [23:0] d_main;
   assign d_main = {m_t, m_o, s_t, s_o, cs_t, cs_o};

   stopwatch_time_counter u_main (
      .clk(clk), .nrst(nrst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
      .gen_ena(gen_ena), .gen_clear(gen_clear),
      .cs_ones(cs_o), .cs_tens(cs_t), .s_ones(s_o), .s_tens(s_t), .m_ones(m_o), .m_tens(m_t),
      .running(running), .lap_active(lap_active), .overflow(overflow));

   // MIN_MAX=1, wrapping
   logic       w_ena, w_gclr, w_run, w_lap, w_ovf;
   logic [3:0] w_cso, w_cst, w_so, w_st, w_mo, w_mt;
   logic [23:0] d_wrap;
   assign d_wrap = {w_mt, w_mo, w_st, w_so, w_cst, w_cso};

   stopwatch_time_counter #(.WRAP(1'b1), .MIN_MAX(1)) u_wrap (
      .clk(clk), .nrst(nrst), .tick(tick2), .start_stop(ss2), .clear(clear2), .lap(lap2),
      .gen_ena(w_ena), .gen_clear(w_gclr),
      .cs_ones(w_cso), .cs_tens(w_cst), .s_ones(w_so), .s_tens(w_st), .m_ones(w_mo), .m_tens(w_mt),
      .running(w_run), .lap_active(w_lap), .overflow(w_ovf));

   // MIN_MAX=1, saturating
   logic       x_ena, x_gclr, x_run, x_lap, x_ovf;
   logic [3:0] x_cso, x_cst, x_so, x_st, x_mo, x_mt;
   logic [23:0] d_sat;
   assign d_sat = {x_mt, x_mo, x_st, x_so, x_cst, x_cso};

   stopwatch_time_counter #(.WRAP(1'b0), .MIN_MAX(1)) u_sat (
      .clk(clk), .nrst(nrst), .tick(tick2), .start_stop(ss2), .clear(clear2), .lap(lap2),
      .gen_ena(x_ena), .gen_clear(x_gclr),
      .cs_ones(x_cso), .cs_tens(x_cst), .s_ones(x_so), .s_tens(x_st), .m_ones(x_mo), .m_tens(x_mt),
      .running(x_run), .lap_active(x_lap), .overflow(x_ovf));

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; cyc(); tick = 1'b0;
         repeat (gap - 1) cyc();
      end
   endtask

   task automatic tick2_n(input int n);
      tick2 = 1'b1;
      repeat (n) cyc();
      tick2 = 1'b0;
   endtask

   task automatic pulse_ss();    start_stop = 1'b1; cyc(); start_stop = 1'b0; endtask
   task automatic pulse_clear(); clear = 1'b1;      cyc(); clear = 1'b0;      endtask
   task automatic pulse_lap();   lap = 1'b1;        cyc(); lap = 1'b0;        endtask

   initial begin
      nrst = 1'b0;
      tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      tick2 = 1'b0; ss2 = 1'b0; clear2 = 1'b0; lap2 = 1'b0;
      #1;
      chk("gen_clear_in_reset_early", 24'(gen_clear), 24'd1);
      repeat (3) cyc();
      chk("reset_digits",     d_main,            24'h000000);
      chk("reset_running",    24'(running),      24'd0);
      chk("reset_gen_ena",    24'(gen_ena),      24'd0);
      chk("reset_gen_clear",  24'(gen_clear),    24'd1);
      chk("reset_lap_active", 24'(lap_active),   24'd0);
      chk("reset_overflow",   24'(overflow),     24'd0);
      chk("reset_wrap_digits", d_wrap,           24'h000000);
      nrst = 1'b1;
      cyc();
      chk("post_reset_gen_clear", 24'(gen_clear), 24'd0);

      // clear mid-count, with a coincident tick that must be dropped
      pulse_ss();
      chk("start_running", 24'(running), 24'd1);
      tick_n(347, 1);
      chk("pre_clear_value", d_main, 24'h000347);
      clear = 1'b1; tick = 1'b1; cyc(); clear = 1'b0; tick = 1'b0;
      chk("clear_digits",    d_main,          24'h000000);
      chk("clear_idle",      24'(running),    24'd0);
      chk("clear_gen_clear", 24'(gen_clear),  24'd1);
      cyc();
      chk("gen_clear_one_cycle", 24'(gen_clear), 24'd0);
      tick_n(3, 1);
      chk("idle_ignores_tick", d_main, 24'h000000);

      // full count with carries, ticks spaced 10 clocks
      pulse_ss();
      tick_n(5999, 10);
      chk("count_005999",   d_main,        24'h005999);
      chk("count_running",  24'(running),  24'd1);
      chk("count_gen_ena",  24'(gen_ena),  24'd1);
      tick_n(1, 10);
      chk("carry_010000",   d_main,        24'h010000);
      chk("no_overflow",    24'(overflow), 24'd0);

      // pause with a coincident tick
      pulse_clear();
      pulse_ss();
      tick_n(41, 1);
      chk("pause_pre", d_main, 24'h000041);
      start_stop = 1'b1; tick = 1'b1; cyc(); start_stop = 1'b0; tick = 1'b0;
      chk("pause_tick_counted", d_main,       24'h000042);
      chk("pause_running",      24'(running), 24'd0);
      tick_n(5, 1);
      chk("paused_hold", d_main, 24'h000042);
      cyc();
      chk("paused_gen_ena", 24'(gen_ena), 24'd0);
      pulse_ss();
      chk("resume_running", 24'(running), 24'd1);
      tick_n(1, 1);
      chk("resume_count", d_main, 24'h000043);

      // lap freeze
      pulse_clear();
      pulse_ss();
      tick_n(120, 1);
      pulse_lap();
      chk("lap_frozen",     d_main,          24'h000120);
      chk("lap_active_set", 24'(lap_active), 24'd1);
      tick_n(30, 1);
      chk("lap_still_frozen", d_main, 24'h000120);
      pulse_lap();
      chk("lap_release",     d_main,          24'h000150);
      chk("lap_active_clr",  24'(lap_active), 24'd0);
      pulse_ss();
      pulse_lap();
      chk("lap_ignored_paused", 24'(lap_active), 24'd0);

      // MIN_MAX=1 terminal count: wrap vs saturate
      ss2 = 1'b1; cyc(); ss2 = 1'b0;
      tick2_n(11999);
      chk("wrap_pre", d_wrap, 24'h015999);
      chk("sat_pre",  d_sat,  24'h015999);
      tick2_n(1);
      chk("wrap_rollover",   d_wrap,       24'h000000);
      chk("wrap_overflow",   24'(w_ovf),   24'd1);
      chk("wrap_running",    24'(w_run),   24'd1);
      chk("sat_hold",        d_sat,        24'h015999);
      chk("sat_overflow",    24'(x_ovf),   24'd1);
      chk("sat_running",     24'(x_run),   24'd0);
      cyc();
      chk("wrap_ovf_pulse",  24'(w_ovf),   24'd0);
      chk("sat_ovf_pulse",   24'(x_ovf),   24'd0);
      chk("sat_gen_ena",     24'(x_ena),   24'd0);
      chk("wrap_gen_ena",    24'(w_ena),   24'd1);
      tick2_n(1);
      chk("wrap_after",      d_wrap,       24'h000001);
      chk("sat_after",       d_sat,        24'h015999);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
